// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared opcodes, flag bit positions and FSM state type for alu_seq
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] c_op_add = 4'b0000;
  localparam logic [3:0] c_op_sub = 4'b0001;
  localparam logic [3:0] c_op_and = 4'b0010;
  localparam logic [3:0] c_op_or  = 4'b0011;
  localparam logic [3:0] c_op_eor = 4'b0100;
  localparam logic [3:0] c_op_adc = 4'b0101;
  localparam logic [3:0] c_op_sbc = 4'b0110;
  localparam logic [3:0] c_op_lsl = 4'b0111;
  localparam logic [3:0] c_op_lsr = 4'b1000;
  localparam logic [3:0] c_op_asr = 4'b1001;
  localparam logic [3:0] c_op_ror = 4'b1010;
  localparam logic [3:0] c_op_mul = 4'b1011;

  localparam int c_flag_n = 3;
  localparam int c_flag_z = 2;
  localparam int c_flag_c = 1;
  localparam int c_flag_v = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_iter
// Brief    : Shift-add multiplier datapath, one multiplier bit per step
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  output logic             last,
  output logic [WIDTH-1:0] acc_next
);

  localparam int            c_cw   = $clog2(WIDTH) + 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [c_cw-1:0]  r_cnt;

  // acc_next is the accumulator after the current step; on the last step it is the product
  assign acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign last     = step && (r_cnt == c_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (load) begin
      r_mcand  <= mcand_in;
      r_mplier <= mplier_in;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (step) begin
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_acc    <= acc_next;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Registered ARM-style ALU with NZCV flags and iterative multiply
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             CarryIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlag
);

  localparam int c_sw     = $clog2(WIDTH);
  localparam bit c_mul_en = (MUL_EN != 0);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flag;
  logic             r_done;

  logic [c_sw-1:0]  w_n;
  logic [c_sw:0]    w_lamt;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_add;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_lsl;
  logic [WIDTH:0]   w_lsr;
  logic [WIDTH:0]   w_asr;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic [3:0]       w_flags;
  logic             w_is_mul;
  logic             w_mul_load;
  logic             w_mul_step;
  logic             w_mul_last;
  logic [WIDTH-1:0] w_prod;

  assign w_is_mul = c_mul_en && (ALUControl == c_op_mul);

  // Single-cycle unit: shared adder plus barrel shifter
  always_comb begin
    w_n       = SrcB[c_sw-1:0];
    w_lamt    = (c_sw + 1)'(WIDTH) - {1'b0, w_n};
    w_b_eff   = ((ALUControl == c_op_sub) || (ALUControl == c_op_sbc)) ? ~SrcB : SrcB;
    w_cin_add = 1'b0;
    if (ALUControl == c_op_sub) begin
      w_cin_add = 1'b1;
    end else if ((ALUControl == c_op_adc) || (ALUControl == c_op_sbc)) begin
      w_cin_add = CarryIn;
    end
    w_sum = {1'b0, SrcA} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin_add};
    // Extra bit below / above the operand catches the last bit shifted out
    w_lsl = {1'b0, SrcA} << w_n;
    w_lsr = {SrcA, 1'b0} >> w_n;
    w_asr = $unsigned($signed({SrcA, 1'b0}) >>> w_n);
    w_ror = (SrcA >> w_n) | (SrcA << w_lamt);

    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (ALUControl)
      c_op_add, c_op_sub, c_op_adc, c_op_sbc: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (SrcA[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != SrcA[WIDTH-1]);
      end
      c_op_and: begin w_res = SrcA & SrcB; w_c = CarryIn; end
      c_op_or:  begin w_res = SrcA | SrcB; w_c = CarryIn; end
      c_op_eor: begin w_res = SrcA ^ SrcB; w_c = CarryIn; end
      c_op_lsl: begin w_res = w_lsl[WIDTH-1:0]; w_c = w_lsl[WIDTH];   end
      c_op_lsr: begin w_res = w_lsr[WIDTH:1];   w_c = w_lsr[0];       end
      c_op_asr: begin w_res = w_asr[WIDTH:1];   w_c = w_asr[0];       end
      c_op_ror: begin w_res = w_ror;            w_c = w_ror[WIDTH-1]; end
      default: begin
        w_res = '0;
        w_c   = 1'b0;
      end
    endcase
    if ((w_n == '0) && ((ALUControl == c_op_lsl) || (ALUControl == c_op_lsr) ||
                        (ALUControl == c_op_asr) || (ALUControl == c_op_ror))) begin
      w_res = SrcA;
      w_c   = CarryIn;
    end
    w_flags = {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_mul_load   = 1'b0;
    w_mul_step   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Start && w_is_mul) begin
          w_state_next = ST_MUL;
          w_mul_load   = 1'b1;
        end
      end
      ST_MUL: begin
        w_mul_step = 1'b1;
        if (w_mul_last) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .reset    (reset),
    .load     (w_mul_load),
    .step     (w_mul_step),
    .mcand_in (SrcA),
    .mplier_in(SrcB),
    .last     (w_mul_last),
    .acc_next (w_prod)
  );

  // MUL leaves C and V as they were
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_flag   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state == ST_IDLE) && Start && !w_is_mul) begin
        r_result <= w_res;
        r_flag   <= w_flags;
        r_done   <= 1'b1;
      end else if (w_mul_last) begin
        r_result <= w_prod;
        r_flag   <= {w_prod[WIDTH-1], (w_prod == '0), r_flag[c_flag_c], r_flag[c_flag_v]};
        r_done   <= 1'b1;
      end
    end
  end

  assign Busy      = (r_state == ST_MUL);
  assign Done      = r_done;
  assign ALUResult = r_result;
  assign ALUFlag   = r_flag;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Directed scoreboard bench for alu_seq (WIDTH=32, MUL_EN=1)
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        CarryIn;
  logic        Busy;
  logic        Done;
  logic [31:0] ALUResult;
  logic [3:0]  ALUFlag;

  int checks = 0;
  int errors = 0;
  logic [35:0] sb[$];

  alu_seq #(.WIDTH(32), .MUL_EN(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (Start),
    .ALUControl(ALUControl),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .CarryIn   (CarryIn),
    .Busy      (Busy),
    .Done      (Done),
    .ALUResult (ALUResult),
    .ALUFlag   (ALUFlag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin);
    Start = 1'b1; ALUControl = op; SrcA = a; SrcB = b; CarryIn = cin;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic [31:0] er, input logic [3:0] ef);
    drive(op, a, b, cin);
    sb.push_back({er, ef});
  endtask

  task automatic pop_cmp(input string tag);
    logic [35:0] e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_res"}, ALUResult, e[35:4]);
      chk({tag, "_flag"}, {28'd0, ALUFlag}, {28'd0, e[3:0]});
    end
  endtask

  // Steps negedges until Done; inject_at>0 pulses a stray Start at that cycle
  task automatic wait_done(input string tag, input int max_cyc, input int inject_at,
                           output int cyc, output int busy_cnt);
    cyc = 0; busy_cnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      Start = 1'b0;
      if (Busy) busy_cnt++;
      if (cyc == inject_at) drive(4'b0000, 32'h1234_5678, 32'h1111_1111, 1'b0);
    end while (!Done && cyc < max_cyc);
    Start = 1'b0;
    chk({tag, "_done"}, {31'd0, Done}, 32'd1);
    if (Done) pop_cmp(tag);
  endtask

  task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic cin, input logic [31:0] er,
                        input logic [3:0] ef);
    int cyc, bc;
    issue(op, a, b, cin, er, ef);
    wait_done(tag, 4, 0, cyc, bc);
    chk({tag, "_lat"}, cyc, 32'd1);
  endtask

  initial begin
    int cyc, bc;
    reset = 1'b1; Start = 1'b0; ALUControl = '0; SrcA = '0; SrcB = '0; CarryIn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_res", ALUResult, 32'd0);
    chk("rst_flag", {28'd0, ALUFlag}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    single("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b1001);
    @(negedge clk);
    chk("done_pulse_once", {31'd0, Done}, 32'd0);
    chk("hold_res", ALUResult, 32'h8000_0000);
    single("sub_eq", 4'b0001, 32'd5, 32'd5, 1'b0, 32'd0, 4'b0110);
    single("sbc_00", 4'b0110, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF, 4'b1000);
    single("adc_wrap", 4'b0101, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'd0, 4'b0110);
    single("lsl1", 4'b0111, 32'h8000_0001, 32'd1, 1'b0, 32'h0000_0002, 4'b0010);
    single("asr4", 4'b1001, 32'h8000_0001, 32'd4, 1'b1, 32'hF800_0000, 4'b1000);
    single("ror1", 4'b1010, 32'h8000_0001, 32'd1, 1'b0, 32'hC000_0000, 4'b1010);
    single("lsr0", 4'b1000, 32'h8000_0001, 32'd0, 1'b1, 32'h8000_0001, 4'b1010);
    single("lsl_hi_ign", 4'b0111, 32'h0000_0001, 32'h0000_0021, 1'b1, 32'h0000_0002, 4'b0000);
    single("undef", 4'b1110, 32'd5, 32'd6, 1'b1, 32'd0, 4'b0100);

    // Back-to-back: Start held for four cycles
    issue(4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hF000_F000, 4'b1010);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      case (i)
        0: issue(4'b0011, 32'h0000_000F, 32'h0000_00F0, 1'b0, 32'h0000_00FF, 4'b0000);
        1: issue(4'b0100, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 32'd0, 4'b0110);
        2: issue(4'b0001, 32'd3, 32'd5, 1'b0, 32'hFFFF_FFFE, 4'b1000);
        default: Start = 1'b0;
      endcase
      chk($sformatf("b2b%0d_done", i), {31'd0, Done}, 32'd1);
      if (Done) pop_cmp($sformatf("b2b%0d", i));
    end

    // Set C,V = 1,1 then multiply; a Start during Busy must be ignored
    single("add_cv", 4'b0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0, 4'b0111);
    issue(4'b1011, 32'h0001_0001, 32'h0001_0001, 1'b0, 32'h0002_0001, 4'b0011);
    wait_done("mul", 40, 5, cyc, bc);
    chk("mul_lat", cyc, 32'd33);
    chk("mul_busy", bc, 32'd32);
    chk("mul_busy_end", {31'd0, Busy}, 32'd0);
    @(negedge clk);
    chk("mul_no_extra_done", {31'd0, Done}, 32'd0);
    chk("mul_sb_empty", sb.size(), 32'd0);

    // Abort a multiply partway through
    issue(4'b1011, 32'd3, 32'd4, 1'b0, 32'd12, 4'b0000);
    repeat (10) begin
      @(negedge clk);
      Start = 1'b0;
    end
    chk("abort_busy_pre", {31'd0, Busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_done", {31'd0, Done}, 32'd0);
    chk("abort_res", ALUResult, 32'd0);
    chk("abort_flag", {28'd0, ALUFlag}, 32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    single("add_after", 4'b0000, 32'd2, 32'd3, 1'b0, 32'd5, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
